pc_fetch_sequencer: RTL and testbench

- Multi-cycle sequencer that owns the program counter and paces it against an instruction memory with variable latency, using a req/ack handshake.
- Samples the branch/jump controls once per instruction, then commits the next PC: sequential, branch or jump.
- Sits between the PC datapath and instruction memory, replacing the free-running per-clock PC update.
- Also provides halt, a fetch watchdog and a retired-instruction count.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/next_pc_calc.sv | 30 +++
 rtl/pc_fetch_sequencer.sv | 112 +++++++++++
 tb/tb_pc_fetch_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the PC fetch sequencer: FSM state encoding and PC constants.
package cpu_pkg;

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_WAIT  = 3'd1,
      S_EXEC  = 3'd2,
      S_HALT  = 3'd3,
      S_ERR   = 3'd4
   } state_e;

   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump beats a taken branch, which beats PC+4.
module next_pc_calc
   import cpu_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [15:0] imm16,
   input  logic [25:0] imm26,
   input  logic        npc_sel,
   input  logic        zero,
   input  logic        jump,
   output logic [31:0] next_pc
);

   logic [31:0] pc4;
   logic [31:0] br_off;

   // Word offset sign-extended and scaled to bytes; additions wrap mod 2^32.
   assign pc4    = pc + PC_STEP;
   assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

   always_comb begin
      if (jump)
         next_pc = {pc4[31:28], imm26, 2'b00};
      else if (npc_sel && zero)
         next_pc = pc4 + br_off;
      else
         next_pc = pc4;
   end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Multi-cycle PC sequencer: paces instruction fetch with a req/ack handshake,
// commits the next PC once per instruction, and provides halt, watchdog and retire count.
module pc_fetch_sequencer
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          TIMEOUT  = 16,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             imem_ack,
   input  logic [15:0]      imm16,
   input  logic [25:0]      imm26,
   input  logic             nPC_sel,
   input  logic             zero,
   input  logic             jump,
   input  logic             halt,
   output logic             imem_req,
   output logic [31:0]      PC,
   output logic             instr_valid,
   output logic             err,
   output logic [CNT_W-1:0] retired
);

   localparam int WD_W = $clog2(TIMEOUT + 1);
   // The counter holds the number of fetch cycles already completed, so the
   // edge that closes the TIMEOUT-th request cycle is the one that trips.
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
   logic [31:0]      next_pc;
   logic             wd_expired;

   next_pc_calc u_next_pc_calc (
      .pc      (pc_q),
      .imm16   (imm16),
      .imm26   (imm26),
      .npc_sel (nPC_sel),
      .zero    (zero),
      .jump    (jump),
      .next_pc (next_pc)
   );

   assign wd_expired = (wd_cnt_q >= WD_LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (!reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_FETCH: state_d = imem_ack ? S_EXEC : S_WAIT;
         S_WAIT: begin
            if (imem_ack)        state_d = S_EXEC;
            else if (wd_expired) state_d = S_ERR;
         end
         S_EXEC:  state_d = halt ? S_HALT : S_FETCH;
         S_HALT:  state_d = S_HALT;
         S_ERR:   state_d = S_ERR;
         default: state_d = S_ERR;
      endcase
   end

   always_comb begin
      imem_req    = (state_q == S_FETCH) || (state_q == S_WAIT);
      instr_valid = (state_q == S_EXEC);
      err         = (state_q == S_ERR);
   end

   // NOTE: every comb output gets a default before the case, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      pc_d      = pc_q;
      retired_d = retired_q;
      wd_cnt_d  = wd_cnt_q;
      unique case (state_q)
         S_FETCH: wd_cnt_d = WD_W'(1);
         S_WAIT: begin
            if (!imem_ack && !wd_expired) wd_cnt_d = wd_cnt_q + WD_W'(1);
         end
         S_EXEC: begin
            pc_d      = next_pc;
            retired_d = retired_q + CNT_W'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q      <= RESET_PC;
         retired_q <= '0;
         wd_cnt_q  <= '0;
      end else begin
         pc_q      <= pc_d;
         retired_q <= retired_d;
         wd_cnt_q  <= wd_cnt_d;
      end
   end

   assign PC      = pc_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed self-checking bench for pc_fetch_sequencer; a second instance
// with RESET_PC=32'hFFFF_FFFC covers PC wrap-around.
module tb_pc_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        imem_ack = 1'b0;
   logic [15:0] imm16 = '0;
   logic [25:0] imm26 = '0;
   logic        nPC_sel = 1'b0;
   logic        zero = 1'b0;
   logic        jump = 1'b0;
   logic        halt = 1'b0;

   logic        imem_req, instr_valid, err;
   logic [31:0] pc, retired;
   logic        w_imem_req, w_instr_valid, w_err;
   logic [31:0] w_pc, w_retired;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pc_fetch_sequencer dut (
      .clk(clk), .reset(reset), .imem_ack(imem_ack), .imm16(imm16), .imm26(imm26),
      .nPC_sel(nPC_sel), .zero(zero), .jump(jump), .halt(halt),
      .imem_req(imem_req), .PC(pc), .instr_valid(instr_valid), .err(err), .retired(retired)
   );

   pc_fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .reset(reset), .imem_ack(imem_ack), .imm16(imm16), .imm26(imm26),
      .nPC_sel(nPC_sel), .zero(zero), .jump(jump), .halt(halt),
      .imem_req(w_imem_req), .PC(w_pc), .instr_valid(w_instr_valid), .err(w_err),
      .retired(w_retired)
   );

   task automatic clear_ctrl();
      imm16 = '0; imm26 = '0; nPC_sel = 1'b0; zero = 1'b0; jump = 1'b0; halt = 1'b0;
   endtask

   // Two reset edges; returns at a falling edge with the DUT in FETCH.
   task automatic do_reset();
      @(negedge clk) reset = 1'b0;
      @(negedge clk);
      @(negedge clk) reset = 1'b1;
   endtask

   task automatic test_reset();
      clear_ctrl();
      imem_ack = 1'b1;
      do_reset();
      checks++; if (pc !== 32'h3000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h3000); end
      checks++; if (retired !== 32'd0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", retired); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
      checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin failures++; $display("FAIL reset_state req=%b valid=%b exp req=1 valid=0", imem_req, instr_valid); end
      checks++; if (w_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_reset_pc got=%h exp=fffffffc", w_pc); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++; if (instr_valid !== 1'b1 || pc !== 32'h3000 + 32'(4 * i)) begin failures++; $display("FAIL seq_exec%0d valid=%b pc=%h exp valid=1 pc=%h", i, instr_valid, pc, 32'h3000 + 32'(4 * i)); end
         @(negedge clk);
         checks++; if (instr_valid !== 1'b0 || pc !== 32'h3004 + 32'(4 * i)) begin failures++; $display("FAIL seq_fetch%0d valid=%b pc=%h exp valid=0 pc=%h", i, instr_valid, pc, 32'h3004 + 32'(4 * i)); end
         checks++; if (retired !== 32'(i + 1)) begin failures++; $display("FAIL seq_retired%0d got=%0d exp=%0d", i, retired, i + 1); end
         if (i == 0) begin
            checks++; if (w_pc !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=00000000", w_pc); end
         end
      end
   endtask

   // One instruction from RESET_PC with the given controls, then check the committed PC.
   task automatic run_one(input string name, input logic [15:0] i16, input logic [25:0] i26,
                          input logic sel, input logic z, input logic j, input logic [31:0] exp_pc);
      imem_ack = 1'b1;
      imm16 = i16; imm26 = i26; nPC_sel = sel; zero = z; jump = j;
      do_reset();
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL %s_exec valid=%b exp=1", name, instr_valid); end
      @(negedge clk);
      checks++; if (pc !== exp_pc) begin failures++; $display("FAIL %s got=%h exp=%h", name, pc, exp_pc); end
      clear_ctrl();
   endtask

   task automatic test_branch();
      run_one("br_fwd", 16'h0001, 26'h0, 1'b1, 1'b1, 1'b0, 32'h3008);
      run_one("br_self", 16'hFFFF, 26'h0, 1'b1, 1'b1, 1'b0, 32'h3000);
      run_one("br_not_taken", 16'h0001, 26'h0, 1'b1, 1'b0, 1'b0, 32'h3004);
   endtask

   task automatic test_jump();
      run_one("jump_prio", 16'h0001, 26'h0000C40, 1'b1, 1'b1, 1'b1, 32'h0000_3100);
   endtask

   task automatic test_wait_states();
      imem_ack = 1'b0;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0 || pc !== 32'h3000) begin failures++; $display("FAIL wait_cyc%0d req=%b valid=%b pc=%h exp req=1 valid=0 pc=3000", i, imem_req, instr_valid, pc); end
         if (i == 5) imem_ack = 1'b1;
         @(negedge clk);
      end
      imem_ack = 1'b0;
      checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL wait_exec valid=%b req=%b exp valid=1 req=0", instr_valid, imem_req); end
      @(negedge clk);
      checks++; if (pc !== 32'h3004 || retired !== 32'd1) begin failures++; $display("FAIL wait_commit pc=%h retired=%0d exp pc=3004 retired=1", pc, retired); end
   endtask

   task automatic test_watchdog();
      imem_ack = 1'b0;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         checks++; if (imem_req !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL wd_cyc%0d req=%b err=%b exp req=1 err=0", i, imem_req, err); end
         @(negedge clk);
      end
      checks++; if (err !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h3000) begin failures++; $display("FAIL wd_trip err=%b req=%b pc=%h exp err=1 req=0 pc=3000", err, imem_req, pc); end
      imem_ack = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (err !== 1'b1 || pc !== 32'h3000 || instr_valid !== 1'b0) begin failures++; $display("FAIL wd_sticky err=%b pc=%h valid=%b exp err=1 pc=3000 valid=0", err, pc, instr_valid); end
      imem_ack = 1'b0;
      do_reset();
      checks++; if (err !== 1'b0 || imem_req !== 1'b1) begin failures++; $display("FAIL wd_clear err=%b req=%b exp err=0 req=1", err, imem_req); end
   endtask

   task automatic test_reset_mid_wait();
      imem_ack = 1'b1;
      do_reset();
      @(negedge clk);
      @(negedge clk);
      imem_ack = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (imem_req !== 1'b1 || pc !== 32'h3004) begin failures++; $display("FAIL midwait_setup req=%b pc=%h exp req=1 pc=3004", imem_req, pc); end
      reset = 1'b0;
      imem_ack = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      checks++; if (pc !== 32'h3000 || err !== 1'b0 || imem_req !== 1'b1 || instr_valid !== 1'b0 || retired !== 32'd0) begin failures++; $display("FAIL midwait_reset pc=%h err=%b req=%b valid=%b retired=%0d exp pc=3000 err=0 req=1 valid=0 retired=0", pc, err, imem_req, instr_valid, retired); end
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL midwait_resume valid=%b exp=1", instr_valid); end
   endtask

   task automatic test_halt();
      logic found;
      found = 1'b0;
      imem_ack = 1'b1;
      do_reset();
      for (int i = 0; i < 20 && !found; i++) begin
         if (instr_valid === 1'b1 && pc === 32'h3010) begin
            found = 1'b1;
            halt = 1'b1;
         end else begin
            halt = !instr_valid;
            @(negedge clk);
         end
      end
      checks++; if (!found) begin failures++; $display("FAIL halt_reach pc=%h exp exec at 3010", pc); end
      @(negedge clk);
      halt = 1'b0;
      checks++; if (pc !== 32'h3014 || retired !== 32'd5 || imem_req !== 1'b0) begin failures++; $display("FAIL halt_commit pc=%h retired=%0d req=%b exp pc=3014 retired=5 req=0", pc, retired, imem_req); end
      for (int i = 0; i < 4; i++) begin
         imem_ack = i[0];
         @(negedge clk);
      end
      checks++; if (pc !== 32'h3014 || retired !== 32'd5 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL halt_frozen pc=%h retired=%0d req=%b valid=%b exp pc=3014 retired=5 req=0 valid=0", pc, retired, imem_req, instr_valid); end
      imem_ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_branch();
      test_jump();
      test_wait_states();
      test_watchdog();
      test_reset_mid_wait();
      test_halt();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
